// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types and elaboration helpers for the single-port RAM controller.
// Holds the FSM state encodings, clog2 and the read-latency legality check.
package ram_sp_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Never returns less than 1, so a DEPTH of 1 still gets a usable index width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Storage for the single-port RAM: registered read with one cycle of latency.
// A write returns its own data (write-first). The array has no reset.
module ram_sp_array
  import ram_sp_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int IDX_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: clears the array after reset, then serves
// req/ready accesses with a READ_LAT-cycle read pipeline and range checking.
module ram_sp_ctrl
  import ram_sp_ctrl_pkg::*;
#(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 16,
  parameter int               DEPTH     = 256,
  parameter int               READ_LAT  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic              init_done
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int AW1   = ADDR_W + 1;
  localparam logic [AW1-1:0]   DEPTH_X = AW1'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("ram_sp_ctrl: READ_LAT must be 1 or 2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              clearing;
  logic              accept;
  logic              in_range;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_din;
  logic [DATA_W-1:0] arr_dout;
  logic [DATA_W-1:0] rd_data;
  logic [READ_LAT-1:0] vpipe;
  logic [READ_LAT-1:0] epipe;
  logic              werr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && cnt == LAST) state_nxt = ST_RUN;
  end

  always_comb begin
    clearing  = (state == ST_CLEAR);
    ready     = (state == ST_RUN);
    init_done = (state == ST_RUN);
  end

  // Handshake: an access is taken on any rising edge where req & ready; ready
  // never depends on req, so accepts can happen on every cycle.
  assign accept   = req & ready;
  assign in_range = {1'b0, addr} < DEPTH_X;
  assign arr_we   = clearing | (accept & we & in_range);
  assign arr_addr = clearing ? cnt : addr[IDX_W-1:0];
  assign arr_din  = clearing ? CLEAR_VAL : din;

  ram_sp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe <= '0;
      epipe <= '0;
      werr  <= 1'b0;
    end else begin
      vpipe[0] <= accept & ~we;
      epipe[0] <= ~in_range;
      for (int i = 1; i < READ_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        epipe[i] <= epipe[i-1];
      end
      werr <= accept & we & ~in_range;
    end
  end

  // Out-of-range reads return zero rather than whatever the aliased index holds.
  assign rd_data = epipe[0] ? '0 : arr_dout;

  if (READ_LAT == 1) begin : g_lat1
    logic [DATA_W-1:0] dout_hold;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dout_hold <= '0;
      else if (vpipe[0]) dout_hold <= rd_data;
    end
    assign dout = vpipe[0] ? rd_data : dout_hold;
  end else begin : g_lat2
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dout_q <= '0;
      else if (vpipe[0]) dout_q <= rd_data;
    end
    assign dout = dout_q;
  end

  assign rvalid = vpipe[READ_LAT-1];
  assign err    = werr | (vpipe[READ_LAT-1] & epipe[READ_LAT-1]);

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed bench for ram_sp_ctrl: a 256x16 READ_LAT=1 instance and a
// 1024x32 READ_LAT=2 instance with a 12-bit address bus, run side by side.
module tb_ram_sp_ctrl;

  logic clk;
  int   checks;
  int   errors;

  logic        rst_a, req_a, we_a;
  logic [15:0] addr_a, din_a, dout_a;
  logic        ready_a, rvalid_a, err_a, init_a;

  logic        rst_b, req_b, we_b;
  logic [11:0] addr_b;
  logic [31:0] din_b, dout_b;
  logic        ready_b, rvalid_b, err_b, init_b;

  logic [31:0] model_b [1024];
  logic [32:0] exp_q [$];

  ram_sp_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .READ_LAT(1), .CLEAR_VAL(16'h0000)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .din(din_a),
    .ready(ready_a), .rvalid(rvalid_a), .dout(dout_a), .err(err_a), .init_done(init_a)
  );

  ram_sp_ctrl #(
    .DATA_W(32), .ADDR_W(12), .DEPTH(1024), .READ_LAT(2), .CLEAR_VAL(32'h0)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .req(req_b), .we(we_b), .addr(addr_b), .din(din_b),
    .ready(ready_b), .rvalid(rvalid_b), .dout(dout_b), .err(err_b), .init_done(init_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A drivers ----------------
  task automatic a_wait_ready(input string tag);
    int n;
    bit saw_rv;
    n = 0;
    saw_rv = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (rvalid_a) saw_rv = 1;
      if (ready_a) break;
    end
    chk({tag, "_sweep_cycles"}, 64'(n), 64'd256);
    chk({tag, "_init_done"}, 64'(init_a), 64'd1);
    chk({tag, "_no_rvalid"}, 64'(saw_rv), 64'd0);
  endtask

  task automatic a_read(input logic [15:0] a, input logic [15:0] exp_d, input logic exp_e,
                        input string tag);
    req_a = 1; we_a = 0; addr_a = a;
    @(negedge clk);
    req_a = 0;
    chk({tag, "_rvalid"}, 64'(rvalid_a), 64'd1);
    chk({tag, "_dout"}, 64'(dout_a), 64'(exp_d));
    chk({tag, "_err"}, 64'(err_a), 64'(exp_e));
  endtask

  task automatic a_write(input logic [15:0] a, input logic [15:0] d, input logic exp_e,
                         input string tag);
    req_a = 1; we_a = 1; addr_a = a; din_a = d;
    @(negedge clk);
    req_a = 0; we_a = 0;
    chk({tag, "_rvalid"}, 64'(rvalid_a), 64'd0);
    chk({tag, "_err"}, 64'(err_a), 64'(exp_e));
  endtask

  task automatic test_a();
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    rst_a = 0; req_a = 0; we_a = 0; addr_a = '0; din_a = '0;
    repeat (2) @(negedge clk);
    chk("a_rst_ready", 64'(ready_a), 64'd0);
    chk("a_rst_rvalid", 64'(rvalid_a), 64'd0);
    chk("a_rst_dout", 64'(dout_a), 64'd0);
    chk("a_rst_err", 64'(err_a), 64'd0);
    chk("a_rst_init", 64'(init_a), 64'd0);
    rst_a = 1;
    a_wait_ready("a_boot");
    a_read(16'h0000, 16'h0000, 1'b0, "a_clr0");
    a_read(16'h0080, 16'h0000, 1'b0, "a_clr128");
    a_read(16'h00FF, 16'h0000, 1'b0, "a_clr255");

    a_write(16'h0010, 16'hBEEF, 1'b0, "a_wr_beef");
    a_read(16'h0010, 16'hBEEF, 1'b0, "a_rd_beef");
    @(negedge clk);
    chk("a_hold_rvalid", 64'(rvalid_a), 64'd0);
    chk("a_hold_dout", 64'(dout_a), 64'hBEEF);

    for (int i = 0; i < 3; i++) a_write(16'(i + 1), vals[i], 1'b0, "a_preload");
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin req_a = 1; we_a = 0; addr_a = 16'(i + 1); end
      else req_a = 0;
      @(negedge clk);
      if (i < 3) begin
        chk("a_b2b_rvalid", 64'(rvalid_a), 64'd1);
        chk("a_b2b_dout", 64'(dout_a), 64'(vals[i]));
      end else begin
        chk("a_b2b_tail_rvalid", 64'(rvalid_a), 64'd0);
      end
    end

    a_read(16'h0100, 16'h0000, 1'b1, "a_oor_rd");
    a_write(16'h0100, 16'hDEAD, 1'b1, "a_oor_wr");
    a_read(16'h0000, 16'h0000, 1'b0, "a_no_alias");
    a_read(16'hFF05, 16'h0000, 1'b1, "a_oor_high");

    // reset with a read in flight
    a_write(16'h0005, 16'h1234, 1'b0, "a_wr5");
    req_a = 1; we_a = 0; addr_a = 16'h0005;
    @(posedge clk);
    #1;
    req_a = 0;
    chk("a_inflight_rvalid", 64'(rvalid_a), 64'd1);
    chk("a_inflight_dout", 64'(dout_a), 64'h1234);
    rst_a = 0;
    #1;
    chk("a_midrst_rvalid", 64'(rvalid_a), 64'd0);
    chk("a_midrst_dout", 64'(dout_a), 64'd0);
    chk("a_midrst_ready", 64'(ready_a), 64'd0);
    chk("a_midrst_init", 64'(init_a), 64'd0);
    repeat (2) @(negedge clk);
    rst_a = 1;
    a_wait_ready("a_reboot1");

    // reset in the middle of the sweep
    a_write(16'h0010, 16'hBEEF, 1'b0, "a_wr_beef2");
    rst_a = 0;
    @(negedge clk);
    rst_a = 1;
    repeat (100) @(negedge clk);
    rst_a = 0;
    #1;
    chk("a_sweeprst_ready", 64'(ready_a), 64'd0);
    @(negedge clk);
    rst_a = 1;
    a_wait_ready("a_reboot2");
    a_read(16'h0010, 16'h0000, 1'b0, "a_recleared");
  endtask

  // ---------------- DUT B drivers ----------------
  task automatic b_write(input logic [11:0] a, input logic [31:0] d, input string tag);
    logic exp_e;
    exp_e = (a >= 12'd1024);
    req_b = 1; we_b = 1; addr_b = a; din_b = d;
    @(negedge clk);
    req_b = 0; we_b = 0;
    chk({tag, "_err"}, 64'(err_b), 64'(exp_e));
    chk({tag, "_rvalid"}, 64'(rvalid_b), 64'd0);
    if (!exp_e) model_b[a[9:0]] = d;
  endtask

  task automatic test_b();
    int n;
    int nrv;
    logic [11:0] ra;
    logic [32:0] e;
    rst_b = 0; req_b = 0; we_b = 0; addr_b = '0; din_b = '0;
    for (int i = 0; i < 1024; i++) model_b[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("b_rst_dout", 64'(dout_b), 64'd0);
    chk("b_rst_ready", 64'(ready_b), 64'd0);
    rst_b = 1;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (ready_b) break;
    end
    chk("b_sweep_cycles", 64'(n), 64'd1024);

    b_write(12'd1, 32'h1111, "b_pre1");
    b_write(12'd2, 32'h2222, "b_pre2");
    b_write(12'd3, 32'h3333, "b_pre3");
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin req_b = 1; we_b = 0; addr_b = 12'(i + 1); end
      else req_b = 0;
      @(negedge clk);
      chk("b_lat2_rvalid", 64'(rvalid_b), (i >= 1 && i <= 3) ? 64'd1 : 64'd0);
      if (i >= 1 && i <= 3) chk("b_lat2_dout", 64'(dout_b), 64'(model_b[i]));
    end

    b_write(12'd1023, 32'hCAFE_F00D, "b_wr1023");
    b_write(12'd1024, 32'h5A5A_5A5A, "b_wr1024");
    b_write(12'd0, 32'h0BAD_0001, "b_wr0");
    for (int i = 0; i < 24; i++)
      b_write(12'($urandom_range(0, 1030)), $urandom, "b_rand_wr");

    // back-to-back reads scored through the expected queue
    nrv = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 24) begin
        case (i)
          0: ra = 12'd1023;
          1: ra = 12'd1024;
          2: ra = 12'd0;
          3: ra = 12'd4095;
          default: ra = 12'($urandom_range(0, 1030));
        endcase
        req_b = 1; we_b = 0; addr_b = ra;
        exp_q.push_back((ra >= 12'd1024) ? {1'b1, 32'h0} : {1'b0, model_b[ra[9:0]]});
      end else begin
        req_b = 0;
      end
      @(negedge clk);
      if (rvalid_b) begin
        nrv++;
        if (exp_q.size() == 0) begin
          chk("b_sb_unexpected_rvalid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("b_sb_dout", 64'(dout_b), 64'(e[31:0]));
          chk("b_sb_err", 64'(err_b), 64'(e[32]));
        end
      end
    end
    chk("b_sb_rvalid_count", 64'(nrv), 64'd24);
    chk("b_sb_leftover", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 0;
    rst_b = 0;
    fork
      test_a();
      test_b();
    join
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
